// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin arbiter/sequencer for one shared DFF bank.
// Ports: CLK/CLR clock and async reset; req/data_in per-requester request
//   and packed data lanes; grant/ack one-hot handshake; Q/Qn bank contents;
//   busy, owner (last writer) and write_cnt (completed writes) status.
module dff_bank_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                   CLK,
   input  logic                   CLR,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] data_in,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       ack,
   output logic [WIDTH-1:0]       Q,
   output logic [WIDTH-1:0]       Qn,
   output logic                   busy,
   output logic [2:0]             owner,
   output logic [CNT_W-1:0]       write_cnt
);

   typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

   localparam logic [2:0] LAST_IDX = 3'(N_REQ - 1);

   state_t           state_q;
   logic [2:0]       last_q;
   logic [2:0]       win_q;
   logic [N_REQ-1:0] grant_q;
   logic [N_REQ-1:0] ack_q;
   logic [WIDTH-1:0] q_q;
   logic             busy_q;
   logic [2:0]       owner_q;
   logic [CNT_W-1:0] cnt_q;

   logic [2:0]       win_d;
   logic             found_d;
   logic [2:0]       cand;
   logic [7:0]       req_ext;

   // Zero-extended to 8 so a 3-bit index always selects in range.
   assign req_ext = 8'(req);

   // Search starts one past the last winner, so the most recent
   // writer ends up with the lowest priority.
   always_comb begin
      found_d = 1'b0;
      win_d   = '0;
      cand    = last_q;
      for (int k = 0; k < N_REQ; k++) begin
         cand = (cand == LAST_IDX) ? 3'd0 : cand + 3'd1;
         if (!found_d && req_ext[cand]) begin
            found_d = 1'b1;
            win_d   = cand;
         end
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q <= IDLE;
         last_q  <= LAST_IDX;
         win_q   <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         q_q     <= '0;
         busy_q  <= 1'b0;
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (found_d) begin
                  grant_q <= N_REQ'(1) << win_d;
                  win_q   <= win_d;
                  busy_q  <= 1'b1;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               grant_q <= '0;
               if (req_ext[win_q]) begin
                  q_q     <= data_in[int'(win_q)*WIDTH +: WIDTH];
                  ack_q   <= N_REQ'(1) << win_q;
                  last_q  <= win_q;
                  owner_q <= win_q;
                  cnt_q   <= cnt_q + CNT_W'(1);
                  state_q <= DONE;
               end else begin
                  // Request withdrawn: abandon without touching the bank.
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            DONE: begin
               ack_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               grant_q <= '0;
               ack_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign grant     = grant_q;
   assign ack       = ack_q;
   assign Q         = q_q;
   assign Qn        = ~q_q;
   assign busy      = busy_q;
   assign owner     = owner_q;
   assign write_cnt = cnt_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter: scoreboard bench for dff_bank_arbiter.
// Expected writes are queued on drive and retired when ack appears.
module tb_dff_bank_arbiter;

   logic        CLK = 1'b0;
   logic        CLR;
   logic [3:0]  req;
   logic [31:0] din;
   logic [3:0]  grant;
   logic [3:0]  ack;
   logic [7:0]  Q;
   logic [7:0]  Qn;
   logic        busy;
   logic [2:0]  owner;
   logic [7:0]  write_cnt;

   typedef struct packed {
      logic [3:0] ack;
      logic [7:0] q;
      logic [2:0] own;
      logic [7:0] cnt;
   } exp_t;

   exp_t       sb[$];
   int         n_chk  = 0;
   int         n_fail = 0;
   int         cyc    = 0;
   int         prev_ack = -1;
   bit         gap_chk  = 1'b0;
   logic [7:0] exp_cnt  = 8'd0;

   dff_bank_arbiter #(.N_REQ(4), .WIDTH(8), .CNT_W(8)) dut (
      .CLK(CLK), .CLR(CLR), .req(req), .data_in(din),
      .grant(grant), .ack(ack), .Q(Q), .Qn(Qn), .busy(busy),
      .owner(owner), .write_cnt(write_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int r, input logic [7:0] d);
      exp_t e;
      exp_cnt = exp_cnt + 8'd1;
      e.ack = 4'(1 << r);
      e.q   = d;
      e.own = 3'(r);
      e.cnt = exp_cnt;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      logic [7:0] qn_exp;
      @(posedge CLK);
      #1;
      cyc++;
      if (grant != 4'b0 && sb.size() > 0)
         check("grant", grant, sb[0].ack);
      if (ack != 4'b0) begin
         if (sb.size() == 0) begin
            check("spurious_ack", ack, 0);
         end else begin
            e = sb.pop_front();
            qn_exp = ~e.q;
            check("ack", ack, e.ack);
            check("Q", Q, e.q);
            check("Qn", Qn, qn_exp);
            check("owner", owner, e.own);
            check("write_cnt", write_cnt, e.cnt);
            check("busy_done", busy, 1);
            if (gap_chk && prev_ack >= 0)
               check("ack_gap", cyc - prev_ack, 3);
            prev_ack = cyc;
            req = req & ~ack;
         end
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((sb.size() != 0 || busy) && n < budget) begin
         tick();
         n++;
      end
      check("drain_left", sb.size(), 0);
      check("drain_busy", busy, 0);
   endtask

   initial begin
      logic [7:0] d;
      int r;
      CLR = 1'b1;
      req = '0;
      din = '0;

      // Reset state
      #11;
      check("rst_Q", Q, 8'h00);
      check("rst_Qn", Qn, 8'hFF);
      check("rst_grant", grant, 0);
      check("rst_ack", ack, 0);
      check("rst_cnt", write_cnt, 0);
      check("rst_busy", busy, 0);
      check("rst_owner", owner, 0);
      #1 CLR = 1'b0;
      repeat (3) tick();
      check("idle_grant", grant, 0);
      check("idle_busy", busy, 0);
      check("idle_Q", Q, 8'h00);

      // Single request; lane changes after grant must still be taken
      req = 4'b0001;
      din[7:0] = 8'h00;
      push(0, 8'hA5);
      tick();
      check("lat_grant", grant, 4'b0001);
      check("lat_busy", busy, 1);
      check("lat_noack", ack, 0);
      din[7:0] = 8'hA5;
      drain(20);

      // Round-robin fairness from reset
      #1 CLR = 1'b1;
      #1 CLR = 1'b0;
      exp_cnt = 8'd0;
      check("rr_rst_cnt", write_cnt, 0);
      din = 32'h44332211;
      req = 4'b1111;
      push(0, 8'h11);
      push(1, 8'h22);
      push(2, 8'h33);
      push(3, 8'h44);
      gap_chk  = 1'b1;
      prev_ack = -1;
      drain(40);
      gap_chk = 1'b0;
      check("rr_cnt", write_cnt, 4);

      // Wrap priority after owner 3
      din[7:0]   = 8'hC1;
      din[31:24] = 8'hD4;
      req = 4'b1001;
      push(0, 8'hC1);
      push(3, 8'hD4);
      drain(30);

      // Withdrawal during GRANT
      req = 4'b0100;
      tick();
      check("wd_grant", grant, 4'b0100);
      req = 4'b0000;
      tick();
      check("wd_ack", ack, 0);
      check("wd_grant0", grant, 0);
      check("wd_busy", busy, 0);
      check("wd_Q", Q, 8'hD4);
      check("wd_cnt", write_cnt, exp_cnt);
      din[23:16] = 8'h77;
      req = 4'b0100;
      push(2, 8'h77);
      drain(20);

      // Reset in the middle of GRANT
      din[7:0] = 8'h3C;
      req = 4'b0001;
      tick();
      check("mr_grant", grant, 4'b0001);
      #2 CLR = 1'b1;
      req = 4'b0000;
      #1;
      check("mr_grant0", grant, 0);
      check("mr_ack0", ack, 0);
      check("mr_Q", Q, 8'h00);
      check("mr_cnt", write_cnt, 0);
      check("mr_busy", busy, 0);
      exp_cnt = 8'd0;
      #4 CLR = 1'b0;
      din[15:8] = 8'h5E;
      req = 4'b0011;
      push(0, 8'h3C);
      push(1, 8'h5E);
      drain(30);

      // Counter wrap across 256 writes
      for (int i = 0; i < 256; i++) begin
         r = i % 4;
         d = 8'(i) ^ 8'h5A;
         din[r*8 +: 8] = d;
         req = 4'(1 << r);
         push(r, d);
         drain(20);
      end
      check("wrap_cnt", write_cnt, exp_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared WIDTH-bit D flip-flop register bank.
- Up to N_REQ requesters compete to load the bank.
- The block grants one requester at a time, loads its data into the bank, acknowledges it, and exposes the stored value as Q/Qn.
- It sits between several producer blocks and the single DFF bank they share.

Parameters:
- N_REQ, 4: number of requesters; must be 2..8.
- WIDTH, 8: width of the shared register and of each data lane.
- CNT_W, 8: width of the completed-write counter.

Ports:
- CLK  input  1  system clock; rising-edge active.
- CLR  input  1  reset; asynchronous, active-high.
- req  input  N_REQ  request bit per requester; level, held until ack.
- data_in  input  N_REQ*WIDTH  packed data lanes; lane i is bits [i*WIDTH +: WIDTH].
- grant  output  N_REQ  one-hot grant, registered.
- ack  output  N_REQ  one-hot, one-cycle pulse when requester's data has been loaded.
- Q  output  WIDTH  shared register contents.
- Qn  output  WIDTH  bitwise complement of Q, always.
- busy  output  1  high whenever state is not IDLE.
- owner  output  3  index of the last requester that completed a write.
- write_cnt  output  CNT_W  number of completed writes; wraps modulo 2^CNT_W.

Behaviour:
- Decided: one clock, CLK. Reset CLR is asynchronous and active-high.
- Reset values (immediate on CLR high, independent of CLK):
  - Q=0, Qn=all ones.
  - grant=0, ack=0, busy=0, owner=0, write_cnt=0.
  - Internal last pointer = N_REQ-1, so requester 0 has first priority.
  - State = IDLE.
- FSM states: IDLE, GRANT, DONE. All outputs are registered.
- IDLE:
  - grant=0, busy=0.
  - At an edge with req!=0: pick the winner by round-robin search starting at (last+1) mod N_REQ, wrapping past N_REQ-1 to 0.
  - On that edge: grant <= onehot(winner), go to GRANT.
  - At an edge with req==0: stay in IDLE.
- GRANT:
  - grant held, busy=1.
  - At the next edge, if req[winner]=1:
    - Q <= lane[winner].
    - ack[winner] <= 1; last <= winner; owner <= winner.
    - write_cnt <= write_cnt+1.
    - grant <= 0; go to DONE.
  - At the next edge, if req[winner]=0 (withdrawn):
    - Q unchanged, no ack, last and write_cnt unchanged.
    - grant <= 0; go to IDLE.
- DONE:
  - ack high for exactly this one cycle, busy=1, grant=0.
  - At the next edge: ack <= 0, go to IDLE.
  - req is not evaluated in DONE.
- Latency: req high before edge k gives:
  - grant high after edge k.
  - Q updated and ack high after edge k+1.
  - ack low and back in IDLE after edge k+2.
- Throughput: at most one write per 3 cycles.
- Requester obligation: drop req in the cycle ack is seen. A req still high in IDLE counts as a new request; round-robin gives it lowest priority.
- Data lanes are sampled only on the GRANT->DONE edge; lane changes before that edge are allowed.
- write_cnt wraps from 2^CNT_W-1 to 0 silently.
- CLR asserted mid-GRANT or mid-DONE aborts the operation: no load, ack and grant forced to 0 immediately.
- Winner is computed combinationally from req and last in IDLE only. grant never has more than one bit set.

Test Plan:
- Reset check: CLR=1 for 12 units, then release.
  - During reset: Q=00, Qn=FF, grant=0, ack=0, write_cnt=0.
  - After release with no req: nothing changes.
- Single request: req=0001, lane0=A5.
  - grant=0001 one cycle later.
  - Q=A5, Qn=5A, ack=0001 the next cycle.
  - write_cnt=1, owner=0.
- Round-robin fairness: req=1111 held; each requester drops req on its ack.
  - Grants come in order 0001, 0010, 0100, 1000, one every 3 cycles.
  - write_cnt=4 at the end.
- Wrap priority: after owner=3, assert req=1001.
  - Requester 0 wins first, then requester 3.
- Withdrawal: req=0100 granted, then req dropped to 0 during GRANT.
  - No ack, Q unchanged, write_cnt unchanged, returns to IDLE.
  - A next req=0100 is still served.
- Reset mid-operation: CLR pulsed during GRANT with lane=3C.
  - Q stays 00, grant and ack are 0 immediately.
  - After release, requester 0 has priority again.
